// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle FETCH/EXEC sequencer for the 9-bit core.
// Owns the program counter, handshakes with instruction memory, loads the
// instruction register, gates architectural writes and counts retirements.
module fetch_sequencer #(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             InstrValid,
  input  logic             Branch,
  input  logic             BranchTaken,
  input  logic [PC_W-1:0]  Target,
  input  logic             HALT,
  output logic [PC_W-1:0]  PC,
  output logic             InstrReq,
  output logic             IR_en,
  output logic             ExecEn,
  output logic             Done,
  output logic [CNT_W-1:0] Retired
);

  localparam logic [PC_W-1:0] LP_START = PC_W'(START_ADDR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_retired;
  logic             r_instr_req;
  logic             r_exec_en;
  logic             r_done;
  logic             w_ir_en;

  // Sequencer FSM: state, PC, retirement counter and registered strobes.
  // The registered strobes are set on the transition into the state that
  // owns them so they exactly track FETCH / EXEC / DONE.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pc        <= LP_START;
      r_retired   <= '0;
      r_instr_req <= 1'b0;
      r_exec_en   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_FETCH;
            r_pc        <= LP_START;
            r_retired   <= '0;
            r_instr_req <= 1'b1;
            r_done      <= 1'b0;
          end
        end
        S_FETCH: begin
          if (InstrValid) begin
            r_state     <= S_EXEC;
            r_instr_req <= 1'b0;
            r_exec_en   <= 1'b1;
          end
        end
        S_EXEC: begin
          r_exec_en <= 1'b0;
          if (r_retired != {CNT_W{1'b1}}) begin
            r_retired <= r_retired + 1'b1;
          end
          // Halt wins over a taken branch; PC stays on the halt instruction.
          if (HALT) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state     <= S_FETCH;
            r_instr_req <= 1'b1;
            if (Branch && BranchTaken) begin
              r_pc <= Target;
            end else begin
              r_pc <= r_pc + 1'b1;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_instr_req <= 1'b0;
          r_exec_en   <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  // IR load is the only Mealy strobe: accept the word in the cycle memory
  // reports it valid. Strobes are also held low while reset is asserted.
  always_comb begin
    w_ir_en = r_instr_req & InstrValid & ~reset;
  end

  assign PC       = r_pc;
  assign Retired  = r_retired;
  assign InstrReq = r_instr_req & ~reset;
  assign IR_en    = w_ir_en;
  assign ExecEn   = r_exec_en & ~reset;
  assign Done     = r_done & ~reset;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table-driven vectors, hand-written corner sequences
// and randomized programs checked against an instruction-level model.
module tb_fetch_sequencer;

  localparam int PC_W  = 10;
  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             reset, start, InstrValid, Branch, BranchTaken, HALT;
  logic [PC_W-1:0]  Target;
  logic [PC_W-1:0]  PC;
  logic             InstrReq, IR_en, ExecEn, Done;
  logic [CNT_W-1:0] Retired;

  int n_checks = 0;
  int n_fail   = 0;

  // Instruction-level model: expected PC of the next fetched instruction
  // and expected retirement count.
  int m_pc  = 0;
  int m_ret = 0;

  fetch_sequencer #(.PC_W(PC_W), .START_ADDR(0), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .reset(reset), .start(start), .InstrValid(InstrValid),
    .Branch(Branch), .BranchTaken(BranchTaken), .Target(Target), .HALT(HALT),
    .PC(PC), .InstrReq(InstrReq), .IR_en(IR_en), .ExecEn(ExecEn),
    .Done(Done), .Retired(Retired)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic st, iv, br, tk;
    logic [PC_W-1:0] tgt;
    logic hl;
    logic [PC_W-1:0] pc;
    logic req, ir, ex, dn;
    logic [CNT_W-1:0] ret;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t mk(input logic st, iv, br, tk, input int tgt,
                              input logic hl, input int pc,
                              input logic req, ir, ex, dn, input int ret);
    vec_t v;
    v.st = st; v.iv = iv; v.br = br; v.tk = tk; v.tgt = PC_W'(tgt); v.hl = hl;
    v.pc = PC_W'(pc); v.req = req; v.ir = ir; v.ex = ex; v.dn = dn;
    v.ret = CNT_W'(ret);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; InstrValid = 0; Branch = 0; BranchTaken = 0; Target = '0; HALT = 0;
  endtask

  // Issue start from IDLE or DONE; next cycle is the first FETCH.
  task automatic start_run();
    clear_inputs();
    start = 1;
    #1 chk("start_noreq", 32'(InstrReq), 0);
    tick();
    start = 0;
    m_pc  = 0;
    m_ret = 0;
  endtask

  // Drive one instruction: w wait cycles, the accepting FETCH cycle, then EXEC.
  task automatic run_instr(input int w, input logic br, tk, input int tgt, input logic hl);
    for (int k = 0; k < w; k++) begin
      InstrValid = 0; start = 1'($urandom); Branch = 1'($urandom);
      BranchTaken = 1'($urandom); Target = PC_W'($urandom); HALT = 1'($urandom);
      #1;
      chk("wait_pc", 32'(PC), 32'(m_pc));
      chk("wait_req", 32'(InstrReq), 1);
      chk("wait_iren", 32'(IR_en), 0);
      chk("wait_exec", 32'(ExecEn), 0);
      tick();
    end
    InstrValid = 1; start = 1'($urandom); Branch = 1'($urandom);
    BranchTaken = 1'($urandom); Target = PC_W'($urandom); HALT = 1'($urandom);
    #1;
    chk("fetch_pc", 32'(PC), 32'(m_pc));
    chk("fetch_req", 32'(InstrReq), 1);
    chk("fetch_iren", 32'(IR_en), 1);
    chk("fetch_exec", 32'(ExecEn), 0);
    chk("fetch_ret", 32'(Retired), 32'(m_ret));
    tick();
    InstrValid = 1'($urandom); start = 1'($urandom);
    Branch = br; BranchTaken = tk; Target = PC_W'(tgt); HALT = hl;
    #1;
    chk("exec_pc", 32'(PC), 32'(m_pc));
    chk("exec_en", 32'(ExecEn), 1);
    chk("exec_iren", 32'(IR_en), 0);
    chk("exec_req", 32'(InstrReq), 0);
    tick();
    clear_inputs();
    if (m_ret < (1 << CNT_W) - 1) m_ret++;
    if (!hl) begin
      if (br && tk) m_pc = tgt % (1 << PC_W);
      else          m_pc = (m_pc + 1) % (1 << PC_W);
    end
  endtask

  task automatic check_done(input string tag);
    InstrValid = 1'($urandom);
    #1;
    chk({tag, "_done"}, 32'(Done), 1);
    chk({tag, "_pc"}, 32'(PC), 32'(m_pc));
    chk({tag, "_ret"}, 32'(Retired), 32'(m_ret));
    chk({tag, "_req"}, 32'(InstrReq), 0);
    chk({tag, "_exec"}, 32'(ExecEn), 0);
    tick();
    InstrValid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //              st iv br tk tgt    hl pc     rq ir ex dn ret
    tbl[0]  = mk(1, 0, 0, 0, 0,     0, 0,     0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0,     0, 0,     1, 1, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0,     0, 0,     0, 0, 1, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 0,     0, 1,     1, 1, 0, 0, 1);
    tbl[4]  = mk(0, 0, 0, 0, 0,     0, 1,     0, 0, 1, 0, 1);
    tbl[5]  = mk(0, 1, 0, 0, 0,     0, 2,     1, 1, 0, 0, 2);
    tbl[6]  = mk(0, 0, 0, 0, 0,     0, 2,     0, 0, 1, 0, 2);
    tbl[7]  = mk(0, 1, 0, 0, 0,     0, 3,     1, 1, 0, 0, 3);
    tbl[8]  = mk(0, 0, 0, 0, 0,     0, 3,     0, 0, 1, 0, 3);
    tbl[9]  = mk(0, 1, 0, 0, 0,     0, 4,     1, 1, 0, 0, 4);
    tbl[10] = mk(0, 0, 0, 0, 0,     0, 4,     0, 0, 1, 0, 4);
    tbl[11] = mk(0, 0, 0, 0, 0,     0, 5,     1, 0, 0, 0, 5);
    tbl[12] = mk(0, 0, 0, 0, 0,     0, 5,     1, 0, 0, 0, 5);
    tbl[13] = mk(0, 0, 0, 0, 0,     0, 5,     1, 0, 0, 0, 5);
    tbl[14] = mk(0, 1, 0, 0, 0,     0, 5,     1, 1, 0, 0, 5);
    tbl[15] = mk(0, 0, 1, 1, 'h3F0, 0, 5,     0, 0, 1, 0, 5);
    tbl[16] = mk(0, 1, 0, 0, 0,     0, 'h3F0, 1, 1, 0, 0, 6);
    tbl[17] = mk(0, 0, 1, 0, 'h123, 0, 'h3F0, 0, 0, 1, 0, 6);
    tbl[18] = mk(0, 1, 0, 0, 0,     0, 'h3F1, 1, 1, 0, 0, 7);
    tbl[19] = mk(0, 0, 1, 1, 'h3FF, 0, 'h3F1, 0, 0, 1, 0, 7);
    tbl[20] = mk(0, 1, 0, 0, 0,     0, 'h3FF, 1, 1, 0, 0, 8);
    tbl[21] = mk(0, 0, 0, 1, 'h055, 0, 'h3FF, 0, 0, 1, 0, 8);
    tbl[22] = mk(1, 1, 0, 0, 0,     0, 0,     1, 1, 0, 0, 9);
    tbl[23] = mk(0, 0, 1, 1, 'h200, 1, 0,     0, 0, 1, 0, 9);
    tbl[24] = mk(0, 1, 0, 0, 0,     0, 0,     0, 0, 0, 1, 10);
    tbl[25] = mk(0, 0, 0, 0, 0,     0, 0,     0, 0, 0, 1, 10);
    tbl[26] = mk(1, 0, 0, 0, 0,     0, 0,     0, 0, 0, 1, 10);
    tbl[27] = mk(0, 0, 0, 0, 0,     0, 0,     1, 0, 0, 0, 0);

    clear_inputs();
    reset = 1;
    tick();
    tick();
    chk("rst_pc", 32'(PC), 0);
    chk("rst_req", 32'(InstrReq), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_ret", 32'(Retired), 0);
    reset = 0;

    // Directed vector table.
    for (int i = 0; i < 28; i++) begin
      start = tbl[i].st; InstrValid = tbl[i].iv; Branch = tbl[i].br;
      BranchTaken = tbl[i].tk; Target = tbl[i].tgt; HALT = tbl[i].hl;
      #1;
      chk($sformatf("vec%0d_pc", i), 32'(PC), 32'(tbl[i].pc));
      chk($sformatf("vec%0d_req", i), 32'(InstrReq), 32'(tbl[i].req));
      chk($sformatf("vec%0d_iren", i), 32'(IR_en), 32'(tbl[i].ir));
      chk($sformatf("vec%0d_exec", i), 32'(ExecEn), 32'(tbl[i].ex));
      chk($sformatf("vec%0d_done", i), 32'(Done), 32'(tbl[i].dn));
      chk($sformatf("vec%0d_ret", i), 32'(Retired), 32'(tbl[i].ret));
      tick();
    end
    clear_inputs();

    // Reset for 3 cycles in the middle of a FETCH with progress made.
    m_pc = 0; m_ret = 0;
    run_instr(0, 0, 0, 0, 0);
    run_instr(0, 0, 0, 0, 0);
    InstrValid = 0;
    #1 chk("pre_rst_req", 32'(InstrReq), 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      reset = 1; start = 1; InstrValid = 1;
      #1;
      chk("rstcyc_iren", 32'(IR_en), 0);
      chk("rstcyc_req", 32'(InstrReq), 0);
      tick();
      chk("rst3_pc", 32'(PC), 0);
      chk("rst3_ret", 32'(Retired), 0);
      chk("rst3_req", 32'(InstrReq), 0);
      chk("rst3_exec", 32'(ExecEn), 0);
      chk("rst3_done", 32'(Done), 0);
    end
    reset = 0; clear_inputs();
    for (int k = 0; k < 10; k++) begin
      InstrValid = 1'($urandom);
      #1;
      chk("idle_req", 32'(InstrReq), 0);
      chk("idle_iren", 32'(IR_en), 0);
      chk("idle_done", 32'(Done), 0);
      tick();
    end
    InstrValid = 0;

    // Halt at PC=7 with a taken branch alongside; then restart from DONE.
    start_run();
    for (int k = 0; k < 7; k++) run_instr(k % 2, 0, 0, 0, 0);
    run_instr(1, 1, 1, 'h1AB, 1);
    check_done("halt7");
    chk("halt7_pc_is7", 32'(PC), 7);
    chk("halt7_ret_is8", 32'(Retired), 8);
    check_done("halt7b");

    // Counter saturation: 20 instructions with a 4-bit counter.
    start_run();
    #1 chk("restart_ret", 32'(Retired), 0);
    for (int k = 0; k < 19; k++) run_instr(0, 0, 0, 0, 0);
    run_instr(0, 0, 0, 0, 1);
    check_done("sat");
    chk("sat_ret_is15", 32'(Retired), 15);

    // Randomized programs.
    for (int r = 0; r < 6; r++) begin
      start_run();
      for (int i = 0; i < 40; i++) begin
        logic hl, br, tk;
        hl = (i == 39) || ($urandom_range(0, 15) == 0);
        br = ($urandom_range(0, 3) == 0);
        tk = 1'($urandom);
        run_instr($urandom_range(0, 3), br, tk, $urandom_range(0, 1023), hl);
        if (hl) break;
      end
      check_done("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
